// File: rtl/bp_pkg.sv
// Shared types for the fetch-side branch predictor: FSM states, 2-bit counter
// encodings and the per-entry storage record.
package bp_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_t;

  // 2-bit counter encodings: strongly/weakly not-taken, weakly/strongly taken
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // Widest tag any legal geometry can need (30 PC bits above pc[1:0]).
  // Narrower tags are zero-extended into this field; the constant upper bits
  // fold away in synthesis.
  localparam int BP_TAG_MAX = 30;

  typedef struct packed {
    logic                  valid;
    logic [BP_TAG_MAX-1:0] tag;
    logic [1:0]            ctr;
    logic [30:0]           target;  // target[31:1]; bit 0 is always 0
  } bp_entry_t;

endpackage

// File: rtl/sat_ctr2.sv
// 2-bit saturating up/down counter next-value logic.
module sat_ctr2
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       inc,
  output logic [1:0] next
);

  // Step towards ST on inc, towards SNT otherwise; hold at either end.
  always_comb begin
    next = ctr;
    if (inc) begin
      if (ctr != ST) next = ctr + 2'd1;
    end else begin
      if (ctr != SNT) next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BHT of 2-bit counters with a
// tagged BTB. Combinational lookup at IF, training from EX/MEM, and a
// one-entry-per-cycle table sweep after reset.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int         INDEX_BITS = 6,
  parameter int         TAG_BITS   = 8,
  parameter logic [1:0] INIT_CTR   = WNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        bp_ready,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_branch,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LSB = INDEX_BITS + 2;
  localparam int TAG_MSB = INDEX_BITS + TAG_BITS + 1;

  function automatic logic [INDEX_BITS-1:0] pc_idx(input logic [31:0] pc);
    return pc[INDEX_BITS+1:2];
  endfunction

  function automatic logic [BP_TAG_MAX-1:0] pc_tag(input logic [31:0] pc);
    logic [BP_TAG_MAX-1:0] t;
    t = '0;
    t[TAG_BITS-1:0] = pc[TAG_MSB:TAG_LSB];
    return t;
  endfunction

  bp_state_t             state_q;
  logic [INDEX_BITS-1:0] sweep_idx_q;
  bp_entry_t             tbl_q [ENTRIES];
  bp_entry_t             tbl_d [ENTRIES];

  logic                  run_live;
  logic [INDEX_BITS-1:0] if_idx;
  bp_entry_t             if_ent;
  logic                  if_hit;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [BP_TAG_MAX-1:0] upd_tag;
  bp_entry_t             upd_ent;
  logic                  upd_hit;
  logic [1:0]            ctr_next;

  // PC bits outside index/tag, and target bit 0, carry no information here.
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], if_pc[31:TAG_MSB+1],
                         upd_pc[1:0], upd_pc[31:TAG_MSB+1], upd_target[0]};

  // Predictions are live only in RUN and never while reset is asserted.
  assign run_live = (state_q == RUN) && !rst;
  assign bp_ready = run_live;

  assign if_idx  = pc_idx(if_pc);
  assign if_ent  = tbl_q[if_idx];
  assign if_hit  = if_ent.valid && (if_ent.tag == pc_tag(if_pc));

  assign upd_idx = pc_idx(upd_pc);
  assign upd_tag = pc_tag(upd_pc);
  assign upd_ent = tbl_q[upd_idx];
  assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

  sat_ctr2 u_sat_ctr2 (
    .ctr  (upd_ent.ctr),
    .inc  (upd_taken),
    .next (ctr_next)
  );

  // Lookup reads registered table state only, so a same-cycle update is not
  // visible until the following cycle.
  always_comb begin
    pred_taken  = run_live && if_hit && if_ent.ctr[1];
    pred_target = pred_taken ? {if_ent.target, 1'b0} : 32'h0;
  end

  // Single table write port: sweep entry during INIT, training during RUN.
  always_comb begin
    tbl_d = tbl_q;
    if (rst) begin
      tbl_d = tbl_q;
    end else if (state_q == INIT) begin
      tbl_d[sweep_idx_q] = '{valid: 1'b0, tag: '0, ctr: INIT_CTR, target: '0};
    end else if (upd_valid) begin
      if (!upd_branch) begin
        tbl_d[upd_idx] = '{valid: 1'b1, tag: upd_tag, ctr: ST,
                           target: upd_target[31:1]};
      end else if (upd_hit) begin
        tbl_d[upd_idx].ctr = ctr_next;
        if (upd_taken) tbl_d[upd_idx].target = upd_target[31:1];
      end else if (upd_taken) begin
        tbl_d[upd_idx] = '{valid: 1'b1, tag: upd_tag, ctr: WT,
                           target: upd_target[31:1]};
      end
    end
  end

  // Table storage has no reset of its own; the sweep initialises it.
  always_ff @(posedge clk) begin
    tbl_q <= tbl_d;
  end

  // INIT/RUN control: sweep every entry once, then stay in RUN until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      sweep_idx_q <= '0;
    end else begin
      case (state_q)
        INIT: begin
          sweep_idx_q <= sweep_idx_q + INDEX_BITS'(1);
          if (sweep_idx_q == INDEX_BITS'(ENTRIES - 1)) state_q <= RUN;
        end
        RUN:     state_q <= RUN;
        default: state_q <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (default geometry: 64 entries,
// 8-bit tag). A reference model predicts every cycle's outputs into a
// scoreboard queue; directed vectors also carry hand-derived expectations.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        bp_ready;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_branch;
  logic        upd_taken;
  logic [31:0] upd_target;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk         (clk),
    .rst         (rst),
    .if_pc       (if_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .bp_ready    (bp_ready),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_branch  (upd_branch),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  typedef struct packed {
    logic        t;
    logic [31:0] tgt;
    logic        rdy;
  } obs_t;

  typedef struct {
    logic [31:0] if_pc;
    logic        uv;
    logic [31:0] upc;
    logic        ub;
    logic        ut;
    logic [31:0] utgt;
    logic        exp_t;
    logic [31:0] exp_tgt;
  } vec_t;

  obs_t sb_q[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  bit          m_run = 1'b0;
  int          m_cnt = 0;
  bit          m_valid [64];
  logic [7:0]  m_tag   [64];
  int          m_ctr   [64];
  logic [31:0] m_tgt   [64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic obs_t model_lookup(input logic r, input logic [31:0] pc);
    obs_t o;
    int   i;
    o = '0;
    i = int'(pc[7:2]);
    if (!r && m_run) begin
      o.rdy = 1'b1;
      if (m_valid[i] && m_tag[i] == pc[15:8] && m_ctr[i] >= 2) begin
        o.t   = 1'b1;
        o.tgt = m_tgt[i];
      end
    end
    return o;
  endfunction

  task automatic model_edge(input logic r, input logic uv, input logic [31:0] upc,
                            input logic ub, input logic ut, input logic [31:0] utgt);
    int  i;
    bit  hit;
    i   = int'(upc[7:2]);
    hit = m_valid[i] && m_tag[i] == upc[15:8];
    if (r) begin
      m_run = 1'b0;
      m_cnt = 0;
    end else if (!m_run) begin
      m_valid[m_cnt] = 1'b0;
      m_ctr[m_cnt]   = 1;
      m_cnt++;
      if (m_cnt == 64) m_run = 1'b1;
    end else if (uv) begin
      if (!ub) begin
        m_valid[i] = 1'b1; m_tag[i] = upc[15:8]; m_ctr[i] = 3; m_tgt[i] = utgt & 32'hFFFF_FFFE;
      end else if (hit) begin
        if (ut) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = utgt & 32'hFFFF_FFFE;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (ut) begin
        m_valid[i] = 1'b1; m_tag[i] = upc[15:8]; m_ctr[i] = 2; m_tgt[i] = utgt & 32'hFFFF_FFFE;
      end
    end
  endtask

  // One clock cycle: drive, predict into scoreboard, sample, compare, advance model.
  task automatic step(input logic r, input logic [31:0] ipc, input logic uv,
                      input logic [31:0] upc, input logic ub, input logic ut,
                      input logic [31:0] utgt, output obs_t got);
    obs_t e;
    @(negedge clk);
    rst = r; if_pc = ipc; upd_valid = uv; upd_pc = upc;
    upd_branch = ub; upd_taken = ut; upd_target = utgt;
    #1;
    sb_q.push_back(model_lookup(r, ipc));
    got = {pred_taken, pred_target, bp_ready};
    e = sb_q.pop_front();
    check("scoreboard", 64'(got), 64'(e));
    @(posedge clk);
    model_edge(r, uv, upc, ub, ut, utgt);
  endtask

  initial begin
    obs_t got;
    int   low_cnt;

    rst = 1'b1; if_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_branch = 1'b0; upd_taken = 1'b0; upd_target = '0;

    // Reset: outputs quiet
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, got);
      check("rst_outputs", 64'(got), 64'h0);
    end

    // Start a sweep, then reset again part-way through (sweep_idx = 30)
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, got);
      if (i == 29) check("first_sweep_not_ready", 64'(got.rdy), 64'h0);
    end
    step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, got);
    check("midsweep_rst_outputs", 64'(got), 64'h0);

    // Restarted sweep: 64 not-ready cycles, JAL updates offered throughout
    low_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, got);
      if (!got.rdy && !got.t) low_cnt++;
    end
    check("init_cycles_not_ready", 64'(low_cnt), 64'd64);
    step(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, got);
    check("ready_on_cycle_65", 64'(got.rdy), 64'h1);
    check("init_updates_dropped", 64'(got.t), 64'h0);

    // Directed vectors: {if_pc, uv, upc, branch, taken, target, exp_taken, exp_target}
    vecs.push_back('{32'h100,   1, 32'h100, 1, 1, 32'h80,   0, 32'h0});
    vecs.push_back('{32'h100,   1, 32'h100, 1, 1, 32'h80,   1, 32'h80});
    vecs.push_back('{32'h100,   0, 32'h0,   0, 0, 32'h0,    1, 32'h80});
    vecs.push_back('{32'h100,   1, 32'h100, 1, 0, 32'h0,    1, 32'h80});
    vecs.push_back('{32'h100,   1, 32'h100, 1, 0, 32'h0,    1, 32'h80});
    vecs.push_back('{32'h100,   1, 32'h100, 1, 0, 32'h0,    0, 32'h0});
    vecs.push_back('{32'h100,   1, 32'h100, 1, 0, 32'h0,    0, 32'h0});
    vecs.push_back('{32'h100,   1, 32'h100, 1, 1, 32'h80,   0, 32'h0});
    vecs.push_back('{32'h100,   1, 32'h100, 1, 1, 32'h80,   0, 32'h0});
    vecs.push_back('{32'h200,   0, 32'h0,   0, 0, 32'h0,    0, 32'h0});
    vecs.push_back('{32'h200,   1, 32'h200, 0, 1, 32'h300,  0, 32'h0});
    vecs.push_back('{32'h200,   0, 32'h0,   0, 0, 32'h0,    1, 32'h300});
    vecs.push_back('{32'h100,   0, 32'h0,   0, 0, 32'h0,    0, 32'h0});
    vecs.push_back('{32'h404,   1, 32'h404, 1, 0, 32'h500,  0, 32'h0});
    vecs.push_back('{32'h404,   0, 32'h0,   0, 0, 32'h0,    0, 32'h0});
    vecs.push_back('{32'h408,   1, 32'h408, 0, 1, 32'h1000, 0, 32'h0});
    vecs.push_back('{32'h408,   1, 32'h408, 1, 0, 32'h2000, 1, 32'h1000});
    vecs.push_back('{32'h408,   1, 32'h408, 1, 1, 32'h3002, 1, 32'h1000});
    vecs.push_back('{32'h408,   0, 32'h0,   0, 0, 32'h0,    1, 32'h3002});
    vecs.push_back('{32'h10200, 0, 32'h0,   0, 0, 32'h0,    1, 32'h300});
    vecs.push_back('{32'h203,   0, 32'h0,   0, 0, 32'h0,    1, 32'h300});
    vecs.push_back('{32'h408,   1, 32'h408, 1, 0, 32'h0,    1, 32'h3002});
    vecs.push_back('{32'h408,   1, 32'h408, 1, 0, 32'h0,    1, 32'h3002});
    vecs.push_back('{32'h408,   1, 32'h408, 0, 1, 32'h4000, 0, 32'h0});
    vecs.push_back('{32'h408,   0, 32'h0,   0, 0, 32'h0,    1, 32'h4000});
    foreach (vecs[k]) begin
      step(1'b0, vecs[k].if_pc, vecs[k].uv, vecs[k].upc, vecs[k].ub, vecs[k].ut, vecs[k].utgt, got);
      check($sformatf("vec%0d", k), 64'({got.t, got.tgt}), 64'({vecs[k].exp_t, vecs[k].exp_tgt}));
    end

    // Random traffic over a few indices and tags, checked against the model
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ipc, upc, tgt;
      ipc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | ($urandom_range(0, 1) << 16);
      upc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) ipc = upc;
      step(1'b0, ipc, 1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), tgt, got);
    end

    // Reset from RUN clears predictions and repeats the sweep
    step(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, got);
    check("run_rst_outputs", 64'(got), 64'h0);
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, got);
    end
    step(1'b0, 32'h408, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, got);
    check("resweep_ready", 64'(got.rdy), 64'h1);
    check("resweep_cleared", 64'(got.t), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
